usb_tx_sequencer: RTL and testbench



---
 rtl/usb_sie_pkg.sv | 25 ++
 rtl/usb_crc16_serial.sv | 29 ++
 rtl/usb_tx_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_sie_pkg.sv
// Shared types and constants for the USB Serial Interface Engine transmit path.
package usb_sie_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP1,
        ST_EOP2,
        ST_EOPJ
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial CRC16 (poly 0x8005) with synchronous clear and per-bit enable.
module usb_crc16_serial
    import usb_sie_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb  = i_bit ^ r_crc[15];
    assign o_crc = r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC16_INIT;
        end else if (i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_enable) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit packet sequencer: SYNC, PID, payload, optional CRC16, EOP.
// Optional CRC16 engine is compiled in with the TX_CRC16_EN macro.
module usb_tx_sequencer
    import usb_sie_pkg::*;
#(
    parameter int         MAX_BYTES    = 64,
    parameter logic [7:0] SYNC_PATTERN = SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pid,
    input  logic       payload_en,
    input  logic       crc_en,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       stuff_en_ok,
    output logic       bs_enable,
    output logic       bs_data,
    output logic       eop,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    tx_state_t       r_state, w_state_nx;
    logic [7:0]      r_shift, w_shift_nx;
    logic [3:0]      r_idx, w_idx_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic            r_last, w_last_nx;
    logic            r_err_seen, w_err_nx;
    logic [7:0]      r_pid;
    logic            r_payload_en;

    logic            w_start_ok;
    logic            w_consume;
    logic            w_fetch_pt;
    logic            w_full;
    logic            w_crc_go;
    logic            w_crc_bit;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign bs_enable  = (r_state == ST_SYNC) || (r_state == ST_PID) ||
                        (r_state == ST_DATA) || (r_state == ST_CRC);
    assign w_consume  = bs_enable & ~stuff_en_ok;

    // Byte fetch happens on the final bit of PID (when payload follows) or of a non-last data byte.
    assign w_fetch_pt = w_consume && (r_idx == 4'd7) &&
                        (((r_state == ST_PID) && r_payload_en) ||
                         ((r_state == ST_DATA) && !r_last));
    assign w_full     = (r_cnt == CW'(MAX_BYTES));
    assign byte_ready = w_fetch_pt & ~w_full & byte_valid;
    assign err        = w_fetch_pt & (w_full | ~byte_valid);

    assign eop     = (r_state == ST_EOP1) || (r_state == ST_EOP2);
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_EOPJ) && !r_err_seen;
    assign bs_data = bs_enable & ((r_state == ST_CRC) ? w_crc_bit : r_shift[0]);

`ifdef TX_CRC16_EN
    logic        r_crc_en;
    logic [15:0] w_crc16;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc_en <= 1'b0;
        end else if (w_start_ok) begin
            r_crc_en <= crc_en;
        end
    end

    usb_crc16_serial u_crc16 (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_start_ok),
        .i_enable (w_consume && (r_state == ST_DATA)),
        .i_bit    (r_shift[0]),
        .o_crc    (w_crc16)
    );

    assign w_crc_go  = r_crc_en;
    assign w_crc_bit = ~w_crc16[r_idx];
`else
    logic w_unused_crc_en;

    assign w_unused_crc_en = crc_en;
    assign w_crc_go        = 1'b0;
    assign w_crc_bit       = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        w_err_nx   = r_err_seen;

        if (w_consume) begin
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_idx_nx   = r_idx + 4'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_SYNC;
                    w_shift_nx = SYNC_PATTERN;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_last_nx  = 1'b0;
                    w_err_nx   = 1'b0;
                end
            end
            ST_SYNC: begin
                if (w_consume && (r_idx == 4'd7)) begin
                    w_state_nx = ST_PID;
                    w_shift_nx = r_pid;
                    w_idx_nx   = '0;
                end
            end
            ST_PID, ST_DATA: begin
                if (w_consume && (r_idx == 4'd7)) begin
                    w_idx_nx = '0;
                    if (w_fetch_pt) begin
                        if (byte_ready) begin
                            w_state_nx = ST_DATA;
                            w_shift_nx = byte_data;
                            w_cnt_nx   = r_cnt + 1'b1;
                            w_last_nx  = byte_last;
                        end else begin
                            w_state_nx = ST_EOP1;
                            w_err_nx   = 1'b1;
                        end
                    end else begin
                        w_state_nx = w_crc_go ? ST_CRC : ST_EOP1;
                    end
                end
            end
            ST_CRC: begin
                if (w_consume && (r_idx == 4'd15)) begin
                    w_state_nx = ST_EOP1;
                    w_idx_nx   = '0;
                end
            end
            ST_EOP1: w_state_nx = ST_EOP2;
            ST_EOP2: w_state_nx = ST_EOPJ;
            ST_EOPJ: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_last       <= 1'b0;
            r_err_seen   <= 1'b0;
            r_pid        <= '0;
            r_payload_en <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_idx      <= w_idx_nx;
            r_cnt      <= w_cnt_nx;
            r_last     <= w_last_nx;
            r_err_seen <= w_err_nx;
            if (w_start_ok) begin
                r_pid        <= pid;
                r_payload_en <= payload_en;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed self-checking bench for usb_tx_sequencer (MAX_BYTES=4 instance).
module tb_usb_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pid = 8'h00;
    logic       payload_en = 1'b0;
    logic       crc_en = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;
    logic       stuff_en_ok = 1'b0;
    logic       byte_ready;
    logic       bs_enable;
    logic       bs_data;
    logic       eop;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tb_bytes [0:7];
    logic        tb_lasts [0:7];
    logic [63:0] stream;
    int          nbits, en_cnt, br_cnt, eop_cnt, done_cnt, err_cnt;
    int          done_cyc, err_cyc, stall_cnt;

    usb_tx_sequencer #(.MAX_BYTES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pid         (pid),
        .payload_en  (payload_en),
        .crc_en      (crc_en),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .stuff_en_ok (stuff_en_ok),
        .bs_enable   (bs_enable),
        .bs_data     (bs_data),
        .eop         (eop),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; edge 0 is the next one, cycle 1 follows it.
    task automatic run_pkt(input logic [7:0] p, input logic pe, input logic ce,
                           input int nbytes, input int drop_idx,
                           input logic stall_mode, input int restart_cyc);
        int   cyc;
        int   bi;
        int   ones;
        logic pending;
        logic prev_stall;
        logic prev_bit;
        stream = '0;
        nbits = 0; en_cnt = 0; br_cnt = 0; eop_cnt = 0; done_cnt = 0; err_cnt = 0;
        done_cyc = -1; err_cyc = -1; stall_cnt = 0;
        cyc = 0; bi = 0; ones = 0; pending = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;
        pid = p; payload_en = pe; crc_en = ce; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            cyc++;
            stuff_en_ok = pending;
            pending = 1'b0;
            if (bi < nbytes && bi != drop_idx) begin
                byte_valid = 1'b1; byte_data = tb_bytes[bi]; byte_last = tb_lasts[bi];
            end else begin
                byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
            end
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) pid = 8'h69;
            #1;
            if (prev_stall) check("stall_hold", bs_data, prev_bit);
            prev_stall = bs_enable && stuff_en_ok;
            prev_bit = bs_data;
            if (bs_enable) begin
                en_cnt++;
                if (!stuff_en_ok) begin
                    if (nbits < 64) stream[nbits] = bs_data;
                    nbits++;
                    if (bs_data) begin
                        ones++;
                        if (stall_mode && (ones % 6 == 0)) pending = 1'b1;
                    end
                end else begin
                    stall_cnt++;
                end
            end
            if (byte_ready) begin
                check("ready_vs_stall", stuff_en_ok, 1'b0);
                bi++;
                br_cnt++;
            end
            if (eop) eop_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (!busy) break;
            if (cyc >= 400) begin
                check("timeout_busy", busy, 1'b0);
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; byte_valid = 1'b0; stuff_en_ok = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tb_bytes[i] = 8'h00;
            tb_lasts[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bs_enable, bs_data, eop, busy, done, err, byte_ready}, 7'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", {bs_enable, bs_data, eop, busy, done, err, byte_ready}, 7'b0);

        // ACK, no stalls, with an ignored start at cycle 5
        run_pkt(8'hD2, 1'b0, 1'b0, 0, -1, 1'b0, 5);
        check("ack_stream", stream, 64'h0000_0000_0000_D280);
        check("ack_nbits", nbits, 16);
        check("ack_enabled", en_cnt, 16);
        check("ack_eop", eop_cnt, 2);
        check("ack_done_cnt", done_cnt, 1);
        check("ack_done_cyc", done_cyc, 19);
        check("ack_err", err_cnt, 0);
        check("ack_ready", br_cnt, 0);
        @(posedge clk); #1;
        check("ack_no_requeue", busy, 1'b0);

        // Zero-length DATA0 with crc_en
        run_pkt(8'hC3, 1'b0, 1'b1, 0, -1, 1'b0, -1);
        check("zlp_stream", stream, 64'h0000_0000_0000_C380);
`ifdef TX_CRC16_EN
        check("zlp_nbits", nbits, 32);
        check("zlp_done_cyc", done_cyc, 35);
`else
        check("zlp_nbits", nbits, 16);
        check("zlp_done_cyc", done_cyc, 19);
`endif
        check("zlp_done_cnt", done_cnt, 1);
        check("zlp_eop", eop_cnt, 2);

        // Payload FF FF with a stall after every 6th consumed one
        tb_bytes[0] = 8'hFF; tb_lasts[0] = 1'b0;
        tb_bytes[1] = 8'hFF; tb_lasts[1] = 1'b1;
        run_pkt(8'hC3, 1'b1, 1'b0, 2, -1, 1'b1, -1);
        check("stall_stream", stream, 64'h0000_0000_FFFF_C380);
        check("stall_nbits", nbits, 32);
        check("stall_count", stall_cnt, 3);
        check("stall_enabled", en_cnt, 35);
        check("stall_ready", br_cnt, 2);
        check("stall_done_cyc", done_cyc, 38);
        check("stall_err", err_cnt, 0);

        // Underrun before the second byte
        tb_bytes[0] = 8'hA5; tb_lasts[0] = 1'b0;
        tb_bytes[1] = 8'h3C; tb_lasts[1] = 1'b1;
        run_pkt(8'hC3, 1'b1, 1'b0, 2, 1, 1'b0, -1);
        check("under_stream", stream, 64'h0000_0000_00A5_C380);
        check("under_ready", br_cnt, 1);
        check("under_err_cnt", err_cnt, 1);
        check("under_err_cyc", err_cyc, 24);
        check("under_eop", eop_cnt, 2);
        check("under_done", done_cnt, 0);

        // Overlength: MAX_BYTES=4, byte_last never set
        for (int i = 0; i < 5; i++) begin
            tb_bytes[i] = 8'(i + 1);
            tb_lasts[i] = 1'b0;
        end
        run_pkt(8'h4B, 1'b1, 1'b0, 5, -1, 1'b0, -1);
        check("over_stream", stream, 64'h0000_0403_0201_4B80);
        check("over_ready", br_cnt, 4);
        check("over_err_cnt", err_cnt, 1);
        check("over_err_cyc", err_cyc, 48);
        check("over_enabled", en_cnt, 48);
        check("over_eop", eop_cnt, 2);
        check("over_done", done_cnt, 0);

        // Reset asserted in the middle of DATA
        pid = 8'hC3; payload_en = 1'b1; crc_en = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check("mid_pre_active", {busy, bs_enable}, 2'b11);
        rst = 1'b1;
        #1;
        check("mid_async_reset", {bs_enable, bs_data, eop, busy, done, err, byte_ready}, 7'b0);
        @(posedge clk); #1;
        check("mid_held_reset", {bs_enable, bs_data, eop, busy, done, err, byte_ready}, 7'b0);
        rst = 1'b0;
        byte_valid = 1'b0;
        run_pkt(8'hD2, 1'b0, 1'b0, 0, -1, 1'b0, -1);
        check("post_rst_stream", stream, 64'h0000_0000_0000_D280);
        check("post_rst_done_cyc", done_cyc, 19);
        check("post_rst_err", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
